serial_mag_compare: RTL and testbench

//   Multi-cycle magnitude comparator for two W-bit unsigned words, scanned one bit per cycle, MSB first.

---
 rtl/serial_cmp_pkg.sv | 18 +
 rtl/bit_cmp_slice.sv | 18 +
 rtl/serial_mag_compare.sv | 156 +++++++++++++++
 tb/tb_serial_mag_compare.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encodings and the helper that sizes the bit counter.
package serial_cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/bit_cmp_slice.sv
// One-bit magnitude comparator slice: reports a>b and a==b for a single
// bit pair. The word-level verdict is folded together by the caller.
module bit_cmp_slice (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq
);

  // Pure combinational bit compare; outputs defaulted first.
  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    gt = a & ~b;
    eq = ~(a ^ b);
  end

endmodule

// File: rtl/serial_mag_compare.sv
// Serial MSB-first magnitude comparator for two W-bit unsigned words.
// One bit pair is examined per cycle through bit_cmp_slice; the word
// verdict (gt/eq/lt) is published with a one-cycle done_tick.
//
// Build option SERIAL_CMP_EARLY_EXIT_EN:
//   defined   - the scan stops at the first differing bit (variable latency)
//   undefined - all W bits are always scanned; the first difference is held
//               in a sticky decided flag so the latency is fixed at W+1.
import serial_cmp_pkg::*;

module serial_mag_compare #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int CW = clog2(W);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
  logic          dec_q, dec_d;   // a difference has already been seen
  logic          dgt_q, dgt_d;   // that difference had a>b
`endif

  logic          s_gt, s_eq;

  bit_cmp_slice u_slice (
    .a  (a_q[W-1]),
    .b  (b_q[W-1]),
    .gt (s_gt),
    .eq (s_eq)
  );

  // Next-state logic: accept, per-bit scan and verdict publication.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    dec_d   = dec_q;
    dgt_d   = dgt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = CW'(W - 1);
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
          dec_d   = 1'b0;
          dgt_d   = 1'b0;
`endif
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        cnt_d = cnt_q - 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (s_gt) begin
          gt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (!s_eq) begin
          lt_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          a_d = {a_q[W-2:0], 1'b0};
          b_d = {b_q[W-2:0], 1'b0};
          if (cnt_q == '0) begin
            eq_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
`else
        // Keep shifting after a decision; later bits are simply ignored.
        a_d = {a_q[W-2:0], 1'b0};
        b_d = {b_q[W-2:0], 1'b0};
        if (!dec_q && !s_eq) begin
          dec_d = 1'b1;
          dgt_d = s_gt;
        end
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (dec_q) begin
            gt_d = dgt_q;
            lt_d = ~dgt_q;
          end else begin
            gt_d = s_gt;
            lt_d = ~s_gt & ~s_eq;
            eq_d = s_eq;
          end
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and verdict registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      dec_q   <= 1'b0;
      dgt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      dec_q   <= dec_d;
      dgt_q   <= dgt_d;
`endif
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done_tick = (state_q == ST_DONE);
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Bench for serial_mag_compare (W=8): directed vector table, busy-start
// and mid-compare reset sequences, and a random back-to-back run scored
// against an arithmetic reference model.
module tb_serial_mag_compare;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         ready, done_tick, gt, eq, lt;

  int n_cmp = 0;
  int n_bad = 0;

  serial_mag_compare #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done_tick (done_tick),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         gt;
    logic         eq;
    logic         lt;
    int           lat_ee;
    int           lat_full;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference latency: cycle index (accept edge = T0) holding done_tick.
  function automatic int ref_lat(input logic [W-1:0] va, input logic [W-1:0] vb);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int m = 0; m < W; m++)
      if (va[W-1-m] != vb[W-1-m]) return m + 2;
`endif
    return W + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge with the DUT idle.
  task automatic run_cmp(input string nm, input vec_t v);
    int cyc;
    int exp_lat;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    exp_lat = v.lat_ee;
`else
    exp_lat = v.lat_full;
`endif
    a = v.a; b = v.b; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cyc = 1;
    check({nm, "_ready_busy"}, ready, 0);
    while (!done_tick && cyc < 20) begin
      step();
      cyc++;
    end
    check({nm, "_latency"}, cyc, exp_lat);
    check({nm, "_gt"}, gt, v.gt);
    check({nm, "_eq"}, eq, v.eq);
    check({nm, "_lt"}, lt, v.lt);
    step();
    check({nm, "_ready_after"}, ready, 1);
    check({nm, "_done_low"}, done_tick, 0);
    check({nm, "_gt_hold"}, gt, v.gt);
  endtask

  initial begin
    int dones, lat_seen, cgt, ceq, clt;
    int accept_at, done_at;
    logic [W-1:0] ra, rb, ma, mb;

    tbl[0] = '{8'hA5, 8'h25, 1'b1, 1'b0, 1'b0, 2, 9};
    tbl[1] = '{8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 9, 9};
    tbl[2] = '{8'h10, 8'h11, 1'b0, 1'b0, 1'b1, 9, 9};
    tbl[3] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 2, 9};
    tbl[4] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 2, 9};
    tbl[5] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 9, 9};
    tbl[6] = '{8'hFE, 8'hFF, 1'b0, 1'b0, 1'b1, 9, 9};
    tbl[7] = '{8'h96, 8'hA6, 1'b0, 1'b0, 1'b1, 4, 9};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_done", done_tick, 0);
    check("rst_gt", gt, 0);
    check("rst_eq", eq, 0);
    check("rst_lt", lt, 0);
    step();

    for (int i = 0; i < 8; i++) run_cmp($sformatf("vec%0d", i), tbl[i]);

    // start while busy is ignored: one compare, one done_tick
    a = 8'h10; b = 8'h11; start = 1'b1;
    step();
    dones = 0; lat_seen = 0; cgt = 0; ceq = 0; clt = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else begin
        start = 1'b0;
      end
      if (done_tick) begin
        dones++; lat_seen = k; cgt = gt; ceq = eq; clt = lt;
      end
      step();
    end
    check("busy_dones", dones, 1);
    check("busy_latency", lat_seen, 9);
    check("busy_gt", cgt, 0);
    check("busy_eq", ceq, 0);
    check("busy_lt", clt, 1);
    check("busy_ready", ready, 1);

    // reset in T4 aborts the compare
    a = 8'h3C; b = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_done", done_tick, 0);
    check("abort_gt", gt, 0);
    check("abort_eq", eq, 0);
    check("abort_lt", lt, 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_tick) dones++;
      step();
    end
    check("abort_no_done", dones, 0);
    check("abort_eq_after", eq, 0);

    // start held high with random operands: back-to-back compares
    start = 1'b1; accept_at = 0; done_at = -1; ma = '0; mb = '0;
    for (int i = 0; i < 44; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      a = ra; b = rb;
      if (i >= 30) start = 1'b0;
      check($sformatf("rnd_done_i%0d", i), done_tick, (i == done_at) ? 1 : 0);
      if (i == done_at) begin
        check($sformatf("rnd_gt_%02h_%02h", ma, mb), gt, (ma > mb) ? 1 : 0);
        check($sformatf("rnd_eq_%02h_%02h", ma, mb), eq, (ma == mb) ? 1 : 0);
        check($sformatf("rnd_lt_%02h_%02h", ma, mb), lt, (ma < mb) ? 1 : 0);
      end
      if (i == accept_at && i < 30) begin
        ma = ra; mb = rb;
        done_at = i + ref_lat(ra, rb);
        accept_at = done_at + 1;
      end
      step();
    end
    check("rnd_final_ready", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
